// File: rtl/evm_pkg.sv
// Shared types and constants for the four-candidate ballot controller.
package evm_pkg;

    localparam int unsigned N_CAND = 4;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_IDLE  = 2'b00;
    localparam mode_t MODE_VOTE  = 2'b01;
    localparam mode_t MODE_CLEAR = 2'b10;
    localparam mode_t MODE_DISP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLD,
        ST_CAST,
        ST_LOCKED,
        ST_CLEAR,
        ST_DONE,
        ST_DISPLAY
    } state_t;

    typedef logic [$clog2(N_CAND)-1:0] cand_idx_t;

    function automatic logic [N_CAND-1:0] cand_onehot(input cand_idx_t c);
        return {{(N_CAND-1){1'b0}}, 1'b1} << c;
    endfunction

    // Only meaningful for a one-hot input.
    function automatic cand_idx_t cand_index(input logic [N_CAND-1:0] b);
        cand_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (b[i]) idx = cand_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/evm_ballot_ctrl_if.sv
// Front-panel inputs and counter/display command outputs of the ballot controller.
interface evm_ballot_ctrl_if;
    import evm_pkg::*;

    mode_t              mode;
    logic               ballot_en;
    logic [N_CAND-1:0]  button;
    logic [N_CAND-1:0]  led;
    logic               ballot_open;
    logic               inc_valid;
    cand_idx_t          inc_sel;
    logic               clr_votes;
    logic               disp_valid;
    cand_idx_t          disp_sel;
    logic               vote_done;
    logic               timeout;
    logic               reject;

    modport master (
        output mode, ballot_en, button,
        input  led, ballot_open, inc_valid, inc_sel, clr_votes,
               disp_valid, disp_sel, vote_done, timeout, reject
    );

    modport slave (
        input  mode, ballot_en, button,
        output led, ballot_open, inc_valid, inc_sel, clr_votes,
               disp_valid, disp_sel, vote_done, timeout, reject
    );

endinterface

// File: rtl/evm_hold_qualifier.sv
// Button qualification: one-hot / multi-press detection, candidate latch and hold counter.
module evm_hold_qualifier
    import evm_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CAND-1:0] button_i,
    input  logic              start_i,
    input  logic              advance_i,
    output logic              single_o,
    output logic              multi_o,
    output logic              qualified_o,
    output logic              broken_o,
    output cand_idx_t         cand_o
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    cand_idx_t     cand_q, cand_d;

    assign single_o    = $onehot(button_i);
    assign multi_o     = (button_i != '0) && !single_o;
    assign qualified_o = (cnt_q == CW'(HOLD_CYCLES));
    assign broken_o    = (button_i != cand_onehot(cand_q));
    assign cand_o      = cand_q;

    // The count survives only while the FSM keeps advancing it; any other cycle zeroes it.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = '0;
        if (start_i) begin
            cand_d = cand_index(button_i);
            cnt_d  = CW'(1);
        end else if (advance_i) begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cand_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            cand_q <= cand_d;
        end
    end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot session FSM: arms one ballot per officer enable, casts one qualified vote, clears and scans the display.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned VOTE_WINDOW = 60,
    parameter int unsigned DISP_CYCLES = 8
) (
    input logic               clk,
    input logic               rst_n,
    evm_ballot_ctrl_if.slave  bus
);

    localparam int unsigned WW = $clog2(VOTE_WINDOW + 1);
    localparam int unsigned SW = $clog2(DISP_CYCLES + 1);

    state_t        state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [SW-1:0] scan_q, scan_d;
    cand_idx_t     disp_sel_q, disp_sel_d;
    logic          reject_q, reject_d;
    logic          timeout_q, timeout_d;

    logic      single, multi, qualified, broken, start, advance;
    cand_idx_t cand;
    logic      vote_mode, expire;

    evm_hold_qualifier #(.HOLD_CYCLES(HOLD_CYCLES)) u_qual (
        .clk        (clk),
        .rst_n      (rst_n),
        .button_i   (bus.button),
        .start_i    (start),
        .advance_i  (advance),
        .single_o   (single),
        .multi_o    (multi),
        .qualified_o(qualified),
        .broken_o   (broken),
        .cand_o     (cand)
    );

    assign vote_mode = (bus.mode == MODE_VOTE);
    assign expire    = (win_q == WW'(1));

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        scan_d     = scan_q;
        disp_sel_d = disp_sel_q;
        reject_d   = 1'b0;
        timeout_d  = 1'b0;
        start      = 1'b0;
        advance    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vote_mode && bus.ballot_en) begin
                    state_d = ST_ARMED;
                    win_d   = WW'(VOTE_WINDOW);
                end else if (bus.mode == MODE_CLEAR) begin
                    state_d = ST_CLEAR;
                end else if (bus.mode == MODE_DISP) begin
                    state_d    = ST_DISPLAY;
                    disp_sel_d = '0;
                    scan_d     = '0;
                end
            end
            ST_ARMED: begin
                win_d = win_q - 1'b1;
                if (!vote_mode) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (single) begin
                    start   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    reject_d = multi;
                end
            end
            ST_HOLD: begin
                // Completion is tested ahead of expiry so a vote landing on the last window cycle counts.
                win_d = win_q - 1'b1;
                if (!vote_mode) begin
                    state_d = ST_IDLE;
                end else if (qualified) begin
                    state_d = ST_CAST;
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (!broken) begin
                    advance = 1'b1;
                end else begin
                    state_d  = ST_ARMED;
                    reject_d = multi;
                end
            end
            ST_CAST:   state_d = ST_LOCKED;
            ST_LOCKED: if (bus.button == '0) state_d = ST_IDLE;
            ST_CLEAR:  state_d = ST_DONE;
            ST_DONE:   if (bus.mode == MODE_IDLE) state_d = ST_IDLE;
            ST_DISPLAY: begin
                if (bus.mode != MODE_DISP) begin
                    state_d    = ST_IDLE;
                    disp_sel_d = '0;
                    scan_d     = '0;
                end else if (scan_q == SW'(DISP_CYCLES - 1)) begin
                    scan_d     = '0;
                    disp_sel_d = disp_sel_q + 1'b1;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            scan_q     <= '0;
            disp_sel_q <= '0;
            reject_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            scan_q     <= scan_d;
            disp_sel_q <= disp_sel_d;
            reject_q   <= reject_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.ballot_open = (state_q == ST_ARMED) || (state_q == ST_HOLD);
    assign bus.inc_valid   = (state_q == ST_CAST);
    assign bus.inc_sel     = (state_q == ST_CAST) ? cand : '0;
    assign bus.vote_done   = (state_q == ST_CAST);
    assign bus.clr_votes   = (state_q == ST_CLEAR);
    assign bus.disp_valid  = (state_q == ST_DISPLAY);
    assign bus.disp_sel    = disp_sel_q;
    assign bus.reject      = reject_q;
    assign bus.timeout     = timeout_q;
    assign bus.led         = ((state_q == ST_HOLD) || (state_q == ST_CAST) || (state_q == ST_LOCKED))
                             ? cand_onehot(cand) : '0;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Randomized and directed bench for evm_ballot_ctrl against a cycle-level behavioural model.
module tb_evm_ballot_ctrl;

    localparam int HOLD = 4;
    localparam int WIN  = 60;
    localparam int DISP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    evm_ballot_ctrl_if bus();

    evm_ballot_ctrl #(
        .HOLD_CYCLES(HOLD),
        .VOTE_WINDOW(WIN),
        .DISP_CYCLES(DISP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: session described by what is open/held/shown rather than by named states.
    bit m_open, m_cast, m_locked, m_clr, m_clr_wait, m_disp, m_rej, m_tmo;
    int m_cand, m_held, m_left, m_disp_cyc;
    int exp_votes [4];
    int obs_votes [4];
    int n_clr_obs, n_tmo_obs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input logic [3:0] b);
        return int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
    endfunction

    task automatic model_reset();
        m_open = 0; m_cast = 0; m_locked = 0; m_clr = 0; m_clr_wait = 0;
        m_disp = 0; m_rej = 0; m_tmo = 0;
        m_cand = 0; m_held = 0; m_left = 0; m_disp_cyc = 0;
    endtask

    task automatic model_step(input logic [1:0] m, input logic ben, input logic [3:0] btn);
        m_rej = 0;
        m_tmo = 0;
        if (m_cast) begin
            m_cast = 0;
            m_locked = 1;
        end else if (m_locked) begin
            if (btn == 4'b0) m_locked = 0;
        end else if (m_clr) begin
            m_clr = 0;
            m_clr_wait = 1;
        end else if (m_clr_wait) begin
            if (m == 2'b00) m_clr_wait = 0;
        end else if (m_disp) begin
            if (m != 2'b11) m_disp = 0;
            else m_disp_cyc++;
        end else if (m_open) begin
            m_left--;
            if (m != 2'b01) begin
                m_open = 0; m_held = 0;
            end else if (m_held == HOLD) begin
                m_open = 0; m_held = 0; m_cast = 1;
                exp_votes[m_cand]++;
            end else if (m_left == 0) begin
                m_open = 0; m_held = 0; m_tmo = 1;
            end else if (m_held > 0) begin
                if (btn == (4'b0001 << m_cand)) m_held++;
                else begin
                    m_held = 0;
                    m_rej = (ones(btn) > 1);
                end
            end else if (ones(btn) == 1) begin
                for (int i = 0; i < 4; i++) if (btn[i]) m_cand = i;
                m_held = 1;
            end else if (ones(btn) > 1) begin
                m_rej = 1;
            end
        end else begin
            if (m == 2'b01 && ben) begin
                m_open = 1; m_left = WIN; m_held = 0;
            end else if (m == 2'b10) begin
                m_clr = 1;
            end else if (m == 2'b11) begin
                m_disp = 1; m_disp_cyc = 0;
            end
        end
    endtask

    function automatic logic [14:0] model_outs();
        logic [3:0] led_e;
        logic [1:0] isel, dsel;
        led_e = ((m_open && m_held > 0) || m_cast || m_locked) ? (4'b0001 << m_cand) : 4'b0;
        isel  = m_cast ? 2'(m_cand) : 2'd0;
        dsel  = m_disp ? 2'((m_disp_cyc / DISP) % 4) : 2'd0;
        return {led_e, m_open, m_cast, isel, m_clr, m_disp, dsel, m_cast, m_tmo, m_rej};
    endfunction

    function automatic logic [14:0] dut_outs();
        return {bus.led, bus.ballot_open, bus.inc_valid, bus.inc_sel, bus.clr_votes,
                bus.disp_valid, bus.disp_sel, bus.vote_done, bus.timeout, bus.reject};
    endfunction

    task automatic cycle(input logic [1:0] m, input logic ben, input logic [3:0] btn);
        bus.mode = m;
        bus.ballot_en = ben;
        bus.button = btn;
        @(posedge clk);
        model_step(m, ben, btn);
        #1;
        if (bus.inc_valid === 1'b1) obs_votes[bus.inc_sel]++;
        if (bus.clr_votes === 1'b1) n_clr_obs++;
        if (bus.timeout === 1'b1) n_tmo_obs++;
        check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
    endtask

    // Called just after a sampling point, so reset lands mid-cycle.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_outs", 32'(dut_outs()), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int lat, n, c0;
        logic [1:0] mode_r;
        logic [3:0] btn;
        int hold_left, len, r;

        for (int i = 0; i < 4; i++) begin exp_votes[i] = 0; obs_votes[i] = 0; end
        n_clr_obs = 0; n_tmo_obs = 0;
        model_reset();
        bus.mode = 2'b00; bus.ballot_en = 1'b0; bus.button = 4'b0;
        #1;
        check_eq("reset_outs", 32'(dut_outs()), 32'd0);
        #21 rst_n = 1'b1;
        cycle(2'b00, 1'b0, 4'b0);

        // Vote for candidate 2, check latency, then retry without officer key.
        cycle(2'b01, 1'b1, 4'b0);
        lat = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(2'b01, 1'b0, 4'b0100);
            if (bus.inc_valid === 1'b1 && lat == 0) begin
                lat = i + 1;
                check_eq("inc_sel2", 32'(bus.inc_sel), 32'd2);
            end
        end
        check_eq("latency", 32'(lat), 32'(HOLD + 1));
        check_eq("led_locked", 32'(bus.led), 32'b0100);
        cycle(2'b01, 1'b0, 4'b0);
        check_eq("led_release", 32'(bus.led), 32'd0);
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b0, 4'b0100);
        check_eq("no_rearm", 32'(obs_votes[2]), 32'd1);
        cycle(2'b00, 1'b0, 4'b0);

        // Multi-press reject then vote for candidate 1.
        cycle(2'b01, 1'b1, 4'b0);
        repeat (2) cycle(2'b01, 1'b0, 4'b0001);
        cycle(2'b01, 1'b0, 4'b0011);
        check_eq("reject", 32'(bus.reject), 32'd1);
        check_eq("rej_open", 32'(bus.ballot_open), 32'd1);
        repeat (6) cycle(2'b01, 1'b0, 4'b0010);
        cycle(2'b01, 1'b0, 4'b0000);
        check_eq("vote_c1", 32'(obs_votes[1]), 32'd1);
        check_eq("no_vote_c0", 32'(obs_votes[0]), 32'd0);
        cycle(2'b00, 1'b0, 4'b0);

        // Window expiry with no press.
        cycle(2'b01, 1'b1, 4'b0);
        n = 0;
        for (int i = 1; i <= 100 && n == 0; i++) begin
            cycle(2'b01, 1'b0, 4'b0);
            if (bus.timeout === 1'b1) n = i;
        end
        check_eq("tmo_cycle", 32'(n), 32'(WIN));
        check_eq("tmo_closed", 32'(bus.ballot_open), 32'd0);
        cycle(2'b01, 1'b0, 4'b0);
        check_eq("tmo_once", 32'(n_tmo_obs), 32'd1);

        // Hold completes on the expiry cycle: the vote wins.
        cycle(2'b01, 1'b1, 4'b0);
        for (int i = 0; i < WIN - HOLD - 1; i++) cycle(2'b01, 1'b0, 4'b0);
        for (int i = 0; i < HOLD + 1; i++) cycle(2'b01, 1'b0, 4'b1000);
        check_eq("race_inc", 32'(bus.inc_valid), 32'd1);
        check_eq("race_tmo", 32'(bus.timeout), 32'd0);
        cycle(2'b00, 1'b0, 4'b0);
        cycle(2'b00, 1'b0, 4'b0);

        // One clear per mode=10 selection.
        c0 = n_clr_obs;
        for (int i = 0; i < 20; i++) cycle(2'b10, 1'b0, 4'b0);
        check_eq("clr_once", 32'(n_clr_obs - c0), 32'd1);
        cycle(2'b00, 1'b0, 4'b0);
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b0, 4'b0);
        check_eq("clr_again", 32'(n_clr_obs - c0), 32'd2);
        cycle(2'b00, 1'b0, 4'b0);
        cycle(2'b00, 1'b0, 4'b0);

        // Display scan.
        for (int k = 1; k <= 40; k++) begin
            cycle(2'b11, 1'b0, 4'b0);
            if ((k - 1) % DISP == 0)
                check_eq($sformatf("disp_sel_k%0d", k), 32'(bus.disp_sel), 32'(((k - 1) / DISP) % 4));
        end
        cycle(2'b00, 1'b0, 4'b0);
        check_eq("disp_off", 32'({bus.disp_valid, bus.disp_sel}), 32'd0);

        // Reset mid-hold; no vote may follow.
        cycle(2'b01, 1'b1, 4'b0);
        repeat (2) cycle(2'b01, 1'b0, 4'b0100);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b0, 4'b0100);
        check_eq("rst_no_vote", 32'(obs_votes[2]), 32'd1);
        cycle(2'b00, 1'b0, 4'b0);

        // Randomized sessions.
        for (int ep = 0; ep < 150; ep++) begin
            if ($urandom_range(0, 99) < 3) do_reset();
            r = int'($urandom_range(0, 9));
            mode_r = (r < 6) ? 2'b01 : (r < 8) ? 2'b11 : (r < 9) ? 2'b10 : 2'b00;
            len = int'($urandom_range(1, 70));
            btn = 4'b0;
            hold_left = 0;
            for (int c = 0; c < len; c++) begin
                if (hold_left == 0) begin
                    r = int'($urandom_range(0, 9));
                    if (r < 3) btn = 4'b0;
                    else if (r < 8) btn = 4'b0001 << $urandom_range(0, 3);
                    else btn = 4'($urandom_range(0, 15));
                    hold_left = int'($urandom_range(1, 8));
                end
                hold_left--;
                cycle(mode_r, ($urandom_range(0, 3) == 0), btn);
            end
            repeat ($urandom_range(0, 2)) cycle(2'b00, 1'b0, 4'b0);
        end

        for (int i = 0; i < 4; i++)
            check_eq($sformatf("votes_c%0d", i), 32'(obs_votes[i]), 32'(exp_votes[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
